// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, fetches over a req/ack
// handshake, presents the word to decode, traps misaligned PCs, counts retires.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] NextPC,
  input  logic        Advance,
  output logic [63:0] CurrentPC,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        FetchFault,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} fetchState_t;

  fetchState_t state, nextState;

  logic [63:0] pcNext;
  logic [31:0] instrNext;
  logic        validNext;
  logic        reqNext;
  logic        faultNext;
  logic [31:0] retireCnt;
  logic [31:0] countNext;

  assign IMemAddr    = CurrentPC;
  assign RetireCount = retireCnt;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      CurrentPC   <= RESET_PC;
      Instruction <= 32'h0;
      InstrValid  <= 1'b0;
      IMemReq     <= 1'b0;
      FetchFault  <= 1'b0;
      retireCnt   <= 32'h0;
    end else begin
      state       <= nextState;
      CurrentPC   <= pcNext;
      Instruction <= instrNext;
      InstrValid  <= validNext;
      IMemReq     <= reqNext;
      FetchFault  <= faultNext;
      retireCnt   <= countNext;
    end
  end

  always_comb begin
    nextState = state;
    pcNext    = CurrentPC;
    instrNext = Instruction;
    validNext = InstrValid;
    reqNext   = IMemReq;
    faultNext = FetchFault;
    countNext = retireCnt;
    case (state)
      IDLE: begin
        reqNext   = 1'b1;
        nextState = FETCH;
      end
      FETCH: begin
        if (IMemAck) begin
          instrNext = IMemData;
          validNext = 1'b1;
          reqNext   = 1'b0;
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (Advance) begin
          countNext = retireCnt + 32'd1;
          pcNext    = NextPC;
          validNext = 1'b0;
          // The bad PC is still latched so the fault can be debugged.
          if (NextPC[1:0] == 2'b00) begin
            reqNext   = 1'b1;
            nextState = FETCH;
          end else begin
            faultNext = 1'b1;
            nextState = FAULT;
          end
        end
      end
      FAULT: begin
        reqNext   = 1'b0;
        validNext = 1'b0;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
